// File: rtl/solar_tracker_2axis.sv
// Two-axis light-balancing sun tracker. Each axis (N-S, E-W) runs its own
// hysteresis FSM with settle delay and run timeout; an optional interlock
// keeps at most one motor running at a time.

module solar_tracker_axis #(
    parameter int W          = 8,
    parameter int TH_START   = 10,
    parameter int TH_STOP    = 2,
    parameter int MAX_RUN    = 255,
    parameter int SETTLE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         fault_clr,
    input  logic         start_ok,   // interlock permission to leave IDLE
    input  logic [W-1:0] p,
    input  logic [W-1:0] q,
    output logic         want,       // would leave IDLE this cycle if permitted
    output logic         moving,
    output logic         mv_p,
    output logic         mv_q,
    output logic         active,
    output logic         flt
);
    typedef enum logic [2:0] {IDLE, MOVE_P, MOVE_Q, SETTLE, FAULT} state_t;

    localparam int CMAX = (MAX_RUN > SETTLE_CYC) ? MAX_RUN : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [W:0]    TS       = (W+1)'(TH_START);
    localparam logic [W:0]    TP       = (W+1)'(TH_STOP);
    localparam logic [CW-1:0] RUN_LAST = CW'(MAX_RUN - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    // One extra bit so reading + threshold can never wrap.
    logic [W:0] pe, qe;
    logic       p_start, q_start, bal;
    assign pe      = {1'b0, p};
    assign qe      = {1'b0, q};
    assign p_start = pe > qe + TS;
    assign q_start = qe > pe + TS;
    assign bal     = (state == MOVE_P) ? (pe <= qe + TP) : (qe <= pe + TP);

    assign want   = (state == IDLE) && en && (p_start || q_start);
    assign mv_p   = (state == MOVE_P);
    assign mv_q   = (state == MOVE_Q);
    assign moving = mv_p || mv_q;
    assign active = (state != IDLE);
    assign flt    = (state == FAULT);

    // State and shared run/settle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state: balance is checked before the timeout so a move that
    // balances on its last allowed cycle settles rather than faults.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (want && start_ok) begin
                    state_n = p_start ? MOVE_P : MOVE_Q;
                    cnt_n   = '0;
                end
            end
            MOVE_P, MOVE_Q: begin
                if (!en)                   state_n = IDLE;
                else if (bal) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
                else if (cnt == RUN_LAST)  state_n = FAULT;
                else                       cnt_n   = cnt + 1'b1;
            end
            SETTLE: begin
                if (!en || cnt == SET_LAST) state_n = IDLE;
                else                        cnt_n   = cnt + 1'b1;
            end
            FAULT: begin
                if (fault_clr) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

module solar_tracker_2axis #(
    parameter int W          = 8,
    parameter int TH_START   = 10,
    parameter int TH_STOP    = 2,
    parameter int MAX_RUN    = 255,
    parameter int SETTLE_CYC = 16,
    parameter int EXCL       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         fault_clr,
    input  logic [W-1:0] lsn,
    input  logic [W-1:0] lse,
    input  logic [W-1:0] lss,
    input  logic [W-1:0] lsw,
    output logic         mn,
    output logic         me,
    output logic         ms,
    output logic         mw,
    output logic         busy,
    output logic [1:0]   fault
);
    // Index 0 = N-S axis, index 1 = E-W axis.
    logic [1:0][W-1:0] p, q;
    logic [1:0] want, moving, mv_p, mv_q, active, flt, start_ok;
    logic       ok_ns, ok_ew;

    assign p = {lse, lsn};
    assign q = {lsw, lss};

    // Interlock: N-S has priority on a simultaneous start; E-W waits while
    // N-S is moving or starting. SETTLE/FAULT of the other axis never block.
    generate
        if (EXCL != 0) begin : g_excl
            assign ok_ns = !moving[1];
            assign ok_ew = !moving[0] && !(want[0] && ok_ns);
        end else begin : g_free
            assign ok_ns = 1'b1;
            assign ok_ew = 1'b1;
        end
    endgenerate
    assign start_ok = {ok_ew, ok_ns};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_ax
            solar_tracker_axis #(
                .W(W), .TH_START(TH_START), .TH_STOP(TH_STOP),
                .MAX_RUN(MAX_RUN), .SETTLE_CYC(SETTLE_CYC)
            ) u_ax (
                .clk(clk), .rst(rst), .en(en), .fault_clr(fault_clr),
                .start_ok(start_ok[g]), .p(p[g]), .q(q[g]),
                .want(want[g]), .moving(moving[g]), .mv_p(mv_p[g]),
                .mv_q(mv_q[g]), .active(active[g]), .flt(flt[g])
            );
        end
    endgenerate

    assign mn    = mv_p[0];
    assign ms    = mv_q[0];
    assign me    = mv_p[1];
    assign mw    = mv_q[1];
    assign busy  = |active;
    assign fault = flt;
endmodule
